// File: rtl/alu_op_sequencer.sv
// ALU instruction sequencer.
// Steps one captured command through LOAD -> EXEC -> [WB -> WRITE] -> DONE and
// drives the datapath strobes. Every output is a flop. Each flop is loaded with
// the decode of the next state and the next captured command, so the outputs
// change in the same cycle as the state.
module alu_op_sequencer #(
  parameter int REG_ADDR_W = 4,
  parameter int DATA_W     = 32,
  parameter int ALU_CTRL_W = 4,
  parameter int MC_CYCLES  = 8,
  parameter int R0_PROTECT = 1
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iStart,
  input  logic [ALU_CTRL_W-1:0] iOp,
  input  logic [REG_ADDR_W-1:0] iRa,
  input  logic [REG_ADDR_W-1:0] iRb,
  input  logic [REG_ADDR_W-1:0] iRc,
  input  logic [DATA_W-1:0]     iImm,
  input  logic                  iUseImm,
  input  logic                  iHiSel,
  input  logic                  iWriteBack,
  input  logic                  iMultiCycle,
  output logic [REG_ADDR_W-1:0] oRF_AddrA,
  output logic [REG_ADDR_W-1:0] oRF_AddrB,
  output logic [REG_ADDR_W-1:0] oRF_AddrC,
  output logic                  oRF_Write,
  output logic                  oRA_en,
  output logic                  oRB_en,
  output logic                  oRZH_en,
  output logic                  oRZL_en,
  output logic                  oRWB_en,
  output logic [ALU_CTRL_W-1:0] oALU_Ctrl,
  output logic                  oMUX_BIS,
  output logic                  oMUX_RZHS,
  output logic [DATA_W-1:0]     oImm32,
  output logic                  oBusy,
  output logic                  oDone
);

  // The EXEC counter only has to reach MC_CYCLES-1.
  localparam int CNT_W = $clog2(MC_CYCLES);
  localparam logic [CNT_W-1:0] MC_LAST = CNT_W'(MC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_EXEC, S_WB, S_WRITE, S_DONE
  } state_t;

  state_t                  r_state, w_state_next;
  logic [CNT_W-1:0]        r_cnt, w_cnt_next;

  // Captured command: current value and next value.
  logic [ALU_CTRL_W-1:0]   r_op, w_op_next;
  logic [REG_ADDR_W-1:0]   r_ra, w_ra_next;
  logic [REG_ADDR_W-1:0]   r_rb, w_rb_next;
  logic [REG_ADDR_W-1:0]   r_rc, w_rc_next;
  logic [DATA_W-1:0]       r_imm, w_imm_next;
  logic                    r_use_imm, w_use_imm_next;
  logic                    r_hi_sel, w_hi_sel_next;
  logic                    r_wb, w_wb_next;
  logic                    r_mc, w_mc_next;

  logic                    w_exec_last;

  // Output flops and their decoded next values.
  logic [REG_ADDR_W-1:0]   r_addr_a, r_addr_b, r_addr_c;
  logic [REG_ADDR_W-1:0]   w_addr_a, w_addr_b, w_addr_c;
  logic                    r_rf_write, r_ra_en, r_rb_en, r_rz_en, r_rwb_en;
  logic                    w_rf_write, w_ra_en, w_rb_en, w_rz_en, w_rwb_en;
  logic [ALU_CTRL_W-1:0]   r_alu_ctrl, w_alu_ctrl;
  logic                    r_bis, r_rzhs, w_bis, w_rzhs;
  logic [DATA_W-1:0]       r_imm_out, w_imm_out;
  logic                    r_busy, r_done, w_busy, w_done;

  // True in the last EXEC cycle of the current command.
  assign w_exec_last = r_mc ? (r_cnt == MC_LAST) : (r_cnt == '0);

  // Next state, EXEC counter and command capture.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_op_next      = r_op;
    w_ra_next      = r_ra;
    w_rb_next      = r_rb;
    w_rc_next      = r_rc;
    w_imm_next     = r_imm;
    w_use_imm_next = r_use_imm;
    w_hi_sel_next  = r_hi_sel;
    w_wb_next      = r_wb;
    w_mc_next      = r_mc;
    case (r_state)
      S_IDLE: begin
        if (iStart) begin
          w_op_next      = iOp;
          w_ra_next      = iRa;
          w_rb_next      = iRb;
          w_rc_next      = iRc;
          w_imm_next     = iImm;
          w_use_imm_next = iUseImm;
          w_hi_sel_next  = iHiSel;
          w_wb_next      = iWriteBack;
          w_mc_next      = iMultiCycle;
          w_state_next   = S_LOAD;
        end
      end
      S_LOAD: begin
        w_cnt_next   = '0;
        w_state_next = S_EXEC;
      end
      S_EXEC: begin
        if (w_exec_last) begin
          w_cnt_next   = '0;
          w_state_next = r_wb ? S_WB : S_DONE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_WB:    w_state_next = S_WRITE;
      S_WRITE: w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Decode the outputs for the coming cycle from the next state and next command.
  always_comb begin
    w_busy     = (w_state_next != S_IDLE);
    w_addr_a   = w_busy ? w_ra_next : '0;
    w_addr_b   = w_busy ? w_rb_next : '0;
    w_addr_c   = w_busy ? w_rc_next : '0;
    w_alu_ctrl = w_busy ? w_op_next : '0;
    w_bis      = w_busy & w_use_imm_next;
    w_rzhs     = w_busy & w_hi_sel_next;
    w_imm_out  = w_busy ? w_imm_next : '0;
    w_ra_en    = (w_state_next == S_LOAD);
    w_rb_en    = (w_state_next == S_LOAD);
    w_rz_en    = (w_state_next == S_EXEC) &&
                 (w_mc_next ? (w_cnt_next == MC_LAST) : (w_cnt_next == '0));
    w_rwb_en   = (w_state_next == S_WB);
    w_rf_write = (w_state_next == S_WRITE) &&
                 !((R0_PROTECT != 0) && (w_rc_next == '0));
    w_done     = (w_state_next == S_DONE);
  end

  // State, counter, captured command and output flops. Reset clears all of them.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_ra       <= '0;
      r_rb       <= '0;
      r_rc       <= '0;
      r_imm      <= '0;
      r_use_imm  <= 1'b0;
      r_hi_sel   <= 1'b0;
      r_wb       <= 1'b0;
      r_mc       <= 1'b0;
      r_addr_a   <= '0;
      r_addr_b   <= '0;
      r_addr_c   <= '0;
      r_alu_ctrl <= '0;
      r_bis      <= 1'b0;
      r_rzhs     <= 1'b0;
      r_imm_out  <= '0;
      r_ra_en    <= 1'b0;
      r_rb_en    <= 1'b0;
      r_rz_en    <= 1'b0;
      r_rwb_en   <= 1'b0;
      r_rf_write <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_op       <= w_op_next;
      r_ra       <= w_ra_next;
      r_rb       <= w_rb_next;
      r_rc       <= w_rc_next;
      r_imm      <= w_imm_next;
      r_use_imm  <= w_use_imm_next;
      r_hi_sel   <= w_hi_sel_next;
      r_wb       <= w_wb_next;
      r_mc       <= w_mc_next;
      r_addr_a   <= w_addr_a;
      r_addr_b   <= w_addr_b;
      r_addr_c   <= w_addr_c;
      r_alu_ctrl <= w_alu_ctrl;
      r_bis      <= w_bis;
      r_rzhs     <= w_rzhs;
      r_imm_out  <= w_imm_out;
      r_ra_en    <= w_ra_en;
      r_rb_en    <= w_rb_en;
      r_rz_en    <= w_rz_en;
      r_rwb_en   <= w_rwb_en;
      r_rf_write <= w_rf_write;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  assign oRF_AddrA = r_addr_a;
  assign oRF_AddrB = r_addr_b;
  assign oRF_AddrC = r_addr_c;
  assign oRF_Write = r_rf_write;
  assign oRA_en    = r_ra_en;
  assign oRB_en    = r_rb_en;
  assign oRZH_en   = r_rz_en;
  assign oRZL_en   = r_rz_en;
  assign oRWB_en   = r_rwb_en;
  assign oALU_Ctrl = r_alu_ctrl;
  assign oMUX_BIS  = r_bis;
  assign oMUX_RZHS = r_rzhs;
  assign oImm32    = r_imm_out;
  assign oBusy     = r_busy;
  assign oDone     = r_done;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Synthesizable control sequencer that issues the per-cycle Datapath strobes for one register-register or register-immediate ALU instruction. Steps: load ALU input registers, execute (optionally multi-cycle), latch result, write back to the register file. A start/busy/done handshake lets the control unit or a bench issue operations back-to-back without hand-written per-state stimulus. Sits between the instruction decoder and Datapath; drives Datapath's RF address, ALU enable, mux and write-enable inputs directly.

Parameters:
REG_ADDR_W, 4, register-file address width
DATA_W, 32, immediate width
ALU_CTRL_W, 4, ALU control code width
MC_CYCLES, 8, EXEC length in cycles when iMultiCycle=1 (>=2)
R0_PROTECT, 1, 1 = suppress RF write when destination address is 0

Ports:
iClk  in  1  clock, all state changes on rising edge
iRst  in  1  synchronous reset, active high
iStart  in  1  command valid; accepted only when oBusy=0
iOp  in  ALU_CTRL_W  ALU control code
iRa  in  REG_ADDR_W  source A register
iRb  in  REG_ADDR_W  source B register
iRc  in  REG_ADDR_W  destination register
iImm  in  DATA_W  immediate operand
iUseImm  in  1  1 = B operand is immediate
iHiSel  in  1  1 = write back ZHigh instead of ZLow
iWriteBack  in  1  0 = compute and latch only, no RF write (compare ops)
iMultiCycle  in  1  1 = EXEC lasts MC_CYCLES
oRF_AddrA  out  REG_ADDR_W  RF read port A address
oRF_AddrB  out  REG_ADDR_W  RF read port B address
oRF_AddrC  out  REG_ADDR_W  RF write address
oRF_Write  out  1  RF write enable
oRA_en  out  1  ALU A input register enable
oRB_en  out  1  ALU B input register enable
oRZH_en  out  1  result-high register enable
oRZL_en  out  1  result-low register enable
oRWB_en  out  1  write-back register enable
oALU_Ctrl  out  ALU_CTRL_W  ALU operation
oMUX_BIS  out  1  B/immediate select
oMUX_RZHS  out  1  result-high select
oImm32  out  DATA_W  immediate to datapath
oBusy  out  1  operation in progress
oDone  out  1  one-cycle completion pulse

Behaviour:
- States: IDLE, LOAD, EXEC, WB, WRITE, DONE. Outputs are registered (Moore, decoded from state and the captured command).
- Reset (iRst high at an edge): state IDLE, cycle counter 0, captured command cleared, every output 0. Reset wins over iStart and aborts any operation mid-flight; no further strobes issue.
- IDLE: oBusy=0, all strobes 0, address/ctrl/imm outputs 0. On iStart=1, capture all command inputs, go to LOAD.
- Inputs are sampled only at acceptance. Changes while busy are ignored. iStart while oBusy=1, including in DONE, is ignored and not queued.
- LOAD (1 cycle): oRA_en=oRB_en=1, oRF_AddrA=Ra, oRF_AddrB=Rb, oMUX_BIS=UseImm, oImm32=Imm. Then go to EXEC.
- EXEC: oALU_Ctrl=Op. Length is 1 cycle, or MC_CYCLES if MultiCycle. oRZH_en=oRZL_en=1 only on the final EXEC cycle. The counter counts up from 0 and leaves EXEC when count = length-1. Then go to WB if WriteBack, else DONE.
- WB (1 cycle): oRWB_en=1, oMUX_RZHS=HiSel.
- WRITE (1 cycle): oRF_AddrC=Rc. oRF_Write=1, except 0 when R0_PROTECT=1 and Rc=0.
- DONE (1 cycle): oDone=1, then go to IDLE.
- oBusy=1 in every state except IDLE.
- Captured oALU_Ctrl, addresses and oMUX_BIS/oMUX_RZHS/oImm32 hold stable from LOAD through DONE.
- Latency from accept edge to oDone:
  - single-cycle, writeback: oDone high in cycle 5
  - single-cycle, no writeback: cycle 3
  - multicycle, writeback: cycle 4+MC_CYCLES
- Next command is accepted at earliest in the first IDLE cycle after DONE.
- At most one of oRA_en, oRZL_en, oRWB_en, oRF_Write is high in any cycle.

Test Plan:
- Reset, then iStart with Op=AND, Ra=3, Rb=7, Rc=4, WriteBack=1 -> LOAD/EXEC/WB/WRITE/DONE in cycles 1-5; oRF_AddrC=4 and oRF_Write=1 only in cycle 4; oDone only in cycle 5; oBusy high cycles 1-5.
- iUseImm=1, iImm=32'h0000_0028 -> oMUX_BIS=1 and oImm32=32'h28 from LOAD through DONE; 0 in IDLE.
- iMultiCycle=1, MC_CYCLES=8, iHiSel=1 -> EXEC for 8 cycles, RZH/RZL enables only in the 8th; oMUX_RZHS=1 in WB; oDone in cycle 12.
- iWriteBack=0 -> no oRWB_en/oRF_Write pulse, oDone in cycle 3; and separately Rc=0 with R0_PROTECT=1 -> WRITE state reached, oRF_Write stays 0.
- iStart asserted continuously with changing iRa -> second op accepted only after DONE→IDLE using iRa sampled at that edge; starts during busy ignored.
- iRst asserted in EXEC of a multicycle op -> next cycle all outputs 0, IDLE; no oRF_Write or oDone ever issued for aborted op.
